// File: rtl/riscv_hazard_ctrl_pkg.sv
// riscv_hazard_ctrl_pkg: shared register-index type, wait-counter width and hazard FSM state encoding
package riscv_hazard_ctrl_pkg;
  localparam int REG_AW = 5;
  localparam int WAIT_W = 8;
  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_MEM_ERR} hz_state_e;
endpackage

// File: rtl/riscv_hazard_detect.sv
// riscv_hazard_detect: load-use comparator; ID rs1/rs2 (+read enables) vs EX load rd, x0 excluded -> load_use
module riscv_hazard_detect
  import riscv_hazard_ctrl_pkg::*;
(
  input  logic      rs1_re,
  input  reg_addr_t rs1_idx,
  input  logic      rs2_re,
  input  reg_addr_t rs2_idx,
  input  reg_addr_t rd_idx,
  input  logic      rd_we,
  input  logic      data_re,
  output logic      load_use
);
  assign load_use = data_re && rd_we && (rd_idx != '0) &&
                    ((rs1_re && rs1_idx == rd_idx) || (rs2_re && rs2_idx == rd_idx));
endmodule

// File: rtl/riscv_hazard_ctrl.sv
// riscv_hazard_ctrl: pipeline stall/flush control (mem wait > branch squash > load-use), watchdog, stall/flush counters; ports: clk, rst, ID/EX hazard inputs, mem req/ready -> stage stall/flush, mem_err, stall_cnt, flush_cnt
module riscv_hazard_ctrl
  import riscv_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  reg_addr_t        id_rs1_idx,
  input  logic             id_rs1_re,
  input  reg_addr_t        id_rs2_idx,
  input  logic             id_rs2_re,
  input  reg_addr_t        ex_rd_idx,
  input  logic             ex_rd_we,
  input  logic             ex_data_re,
  input  logic             ex_br_taken,
  input  logic             mem_data_req,
  input  logic             mem_data_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  hz_state_e         state, state_nx;
  logic [WAIT_W-1:0] wcnt, wcnt_nx;
  logic              load_use, err, mem_wait, br, lu, last;
  riscv_hazard_detect u_detect (
    .rs1_re   (id_rs1_re),
    .rs1_idx  (id_rs1_idx),
    .rs2_re   (id_rs2_re),
    .rs2_idx  (id_rs2_idx),
    .rd_idx   (ex_rd_idx),
    .rd_we    (ex_rd_we),
    .data_re  (ex_data_re),
    .load_use (load_use)
  );
  assign err      = state == ST_MEM_ERR;
  assign mem_wait = !err && mem_data_req && !mem_data_ready;
  assign br       = !err && !mem_wait && ex_br_taken;
  assign lu       = !err && !mem_wait && !ex_br_taken && load_use;
  // wcnt holds the not-ready cycles already seen, so this cycle is the last tolerated one
  assign last     = wcnt == WAIT_W'(MEM_TIMEOUT - 1);
  assign mem_err  = err;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      wcnt      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nx;
      wcnt      <= wcnt_nx;
      stall_cnt <= stall_cnt + CNT_W'(pc_stall);
      flush_cnt <= flush_cnt + CNT_W'(if_id_flush);
    end
  end
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    if (!err) begin
      state_nx = mem_wait ? (last ? ST_MEM_ERR : ST_MEM_WAIT) : ST_RUN;
      wcnt_nx  = mem_wait ? wcnt + WAIT_W'(1) : '0;
    end
  end
  always_comb begin
    pc_stall     = !rst && (err || mem_wait || lu);
    if_id_stall  = !rst && (err || mem_wait || lu);
    if_id_flush  = !rst && br;
    id_ex_stall  = !rst && (err || mem_wait);
    id_ex_flush  = !rst && (br || lu);
    ex_mem_stall = !rst && (err || mem_wait);
    mem_wb_flush = !rst && (err || mem_wait);
  end
endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// tb_riscv_hazard_ctrl: directed self-checking bench for riscv_hazard_ctrl (MEM_TIMEOUT=4/CNT_W=4 main, MEM_TIMEOUT=1 side instance)
module tb_riscv_hazard_ctrl;
  logic       clk = 0;
  logic       rst;
  logic [4:0] id_rs1_idx, id_rs2_idx, ex_rd_idx;
  logic       id_rs1_re, id_rs2_re, ex_rd_we, ex_data_re, ex_br_taken, mem_data_req, mem_data_ready;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush, mem_err;
  logic [3:0] stall_cnt, flush_cnt;
  logic       b_pc_stall, b_if_id_stall, b_if_id_flush, b_id_ex_stall, b_id_ex_flush, b_ex_mem_stall, b_mem_wb_flush, b_mem_err;
  logic [31:0] b_stall_cnt, b_flush_cnt;
  logic [6:0] ctl;
  int         n_chk = 0, n_pass = 0;
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1100100;
  localparam logic [6:0] BR   = 7'b0010100;
  localparam logic [6:0] MW   = 7'b1101011;
  always #5 clk = ~clk;
  assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush};
  riscv_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst),
    .id_rs1_idx(id_rs1_idx), .id_rs1_re(id_rs1_re), .id_rs2_idx(id_rs2_idx), .id_rs2_re(id_rs2_re),
    .ex_rd_idx(ex_rd_idx), .ex_rd_we(ex_rd_we), .ex_data_re(ex_data_re), .ex_br_taken(ex_br_taken),
    .mem_data_req(mem_data_req), .mem_data_ready(mem_data_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall),
    .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall), .mem_wb_flush(mem_wb_flush),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  riscv_hazard_ctrl #(.MEM_TIMEOUT(1), .CNT_W(32)) u_t1 (
    .clk(clk), .rst(rst),
    .id_rs1_idx(id_rs1_idx), .id_rs1_re(id_rs1_re), .id_rs2_idx(id_rs2_idx), .id_rs2_re(id_rs2_re),
    .ex_rd_idx(ex_rd_idx), .ex_rd_we(ex_rd_we), .ex_data_re(ex_data_re), .ex_br_taken(ex_br_taken),
    .mem_data_req(mem_data_req), .mem_data_ready(mem_data_ready),
    .pc_stall(b_pc_stall), .if_id_stall(b_if_id_stall), .if_id_flush(b_if_id_flush), .id_ex_stall(b_id_ex_stall),
    .id_ex_flush(b_id_ex_flush), .ex_mem_stall(b_ex_mem_stall), .mem_wb_flush(b_mem_wb_flush),
    .mem_err(b_mem_err), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    {id_rs1_idx, id_rs2_idx, ex_rd_idx} = '0;
    {id_rs1_re, id_rs2_re, ex_rd_we, ex_data_re, ex_br_taken, mem_data_req, mem_data_ready} = '0;
  endtask
  task automatic set_lu;
    ex_data_re = 1; ex_rd_we = 1; ex_rd_idx = 5'd5;
    id_rs2_re = 1; id_rs2_idx = 5'd5; id_rs1_re = 1; id_rs1_idx = 5'd3;
  endtask
  initial begin
    idle;
    rst = 1;
    mem_data_req = 1; ex_br_taken = 1; set_lu;
    #1;
    chk("rst_ctl_zero", 32'(ctl), 32'(NONE));
    step; step;
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_flush_cnt", 32'(flush_cnt), 0);
    chk("rst_mem_err", 32'(mem_err), 0);
    idle; rst = 0;
    #1;
    chk("idle_ctl", 32'(ctl), 32'(NONE));
    set_lu;
    #1;
    chk("lu_rs2_ctl", 32'(ctl), 32'(LU));
    step;
    ex_data_re = 0;
    #1;
    chk("lu_one_cycle", 32'(ctl), 32'(NONE));
    chk("lu_stall_cnt", 32'(stall_cnt), 1);
    set_lu; ex_rd_idx = 0; id_rs2_idx = 0; id_rs1_idx = 0;
    #1;
    chk("lu_x0_ctl", 32'(ctl), 32'(NONE));
    step;
    chk("lu_x0_stall_cnt", 32'(stall_cnt), 1);
    set_lu; ex_rd_idx = 7; id_rs1_idx = 7; id_rs1_re = 0;
    #1;
    chk("lu_rs1_no_re", 32'(ctl), 32'(NONE));
    id_rs1_re = 1;
    #1;
    chk("lu_rs1_ctl", 32'(ctl), 32'(LU));
    ex_data_re = 0;
    #1;
    chk("no_load_ctl", 32'(ctl), 32'(NONE));
    ex_data_re = 1;
    step;
    chk("lu_rs1_stall_cnt", 32'(stall_cnt), 2);
    set_lu; ex_br_taken = 1;
    #1;
    chk("br_ctl", 32'(ctl), 32'(BR));
    chk("br_flush_before", 32'(flush_cnt), 0);
    step;
    chk("br_flush_cnt", 32'(flush_cnt), 1);
    chk("br_stall_cnt", 32'(stall_cnt), 2);
    set_lu; ex_br_taken = 1; mem_data_req = 1; mem_data_ready = 0;
    #1;
    chk("mw_c1_ctl", 32'(ctl), 32'(MW));
    chk("t1_c1_ctl", 32'({b_pc_stall, b_mem_wb_flush}), 32'h3);
    step;
    chk("t1_err_after_1", 32'(b_mem_err), 1);
    chk("mw_c2_ctl", 32'(ctl), 32'(MW));
    step;
    chk("mw_c3_ctl", 32'(ctl), 32'(MW));
    step;
    idle; mem_data_req = 1; mem_data_ready = 1;
    #1;
    chk("mw_ready_ctl", 32'(ctl), 32'(NONE));
    chk("mw_stall_cnt", 32'(stall_cnt), 5);
    chk("mw_no_flush", 32'(flush_cnt), 1);
    step;
    idle;
    #1;
    chk("mw_back_run", 32'(ctl), 32'(NONE));
    chk("mw_no_err", 32'(mem_err), 0);
    mem_data_req = 1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("wd_c%0d_ctl", i), 32'(ctl), 32'(MW));
      chk($sformatf("wd_c%0d_err", i), 32'(mem_err), 0);
      step;
    end
    chk("wd_err_set", 32'(mem_err), 1);
    chk("wd_stall_cnt", 32'(stall_cnt), 9);
    mem_data_ready = 1; ex_br_taken = 1;
    #1;
    chk("wd_err_ctl", 32'(ctl), 32'(MW));
    step;
    mem_data_req = 0; mem_data_ready = 0;
    #1;
    chk("wd_err_sticky", 32'(mem_err), 1);
    chk("wd_err_ctl2", 32'(ctl), 32'(MW));
    chk("wd_err_stall_cnt", 32'(stall_cnt), 10);
    rst = 1;
    #1;
    chk("wd_rst_ctl", 32'(ctl), 32'(NONE));
    step;
    rst = 0; idle;
    #1;
    chk("wd_rst_err", 32'(mem_err), 0);
    chk("wd_rst_stall_cnt", 32'(stall_cnt), 0);
    chk("wd_rst_flush_cnt", 32'(flush_cnt), 0);
    chk("t1_rst_err", 32'(b_mem_err), 0);
    chk("wd_rst_ctl_run", 32'(ctl), 32'(NONE));
    mem_data_req = 1;
    step;
    #1;
    chk("rmw_c2_ctl", 32'(ctl), 32'(MW));
    rst = 1;
    #1;
    chk("rmw_rst_ctl", 32'(ctl), 32'(NONE));
    step;
    rst = 0;
    mem_data_ready = 1;
    #1;
    chk("rmw_run_ctl", 32'(ctl), 32'(NONE));
    chk("rmw_stall_cnt", 32'(stall_cnt), 0);
    mem_data_ready = 0;
    for (int i = 0; i < 3; i++) step;
    chk("rmw_wcnt_cleared", 32'(mem_err), 0);
    idle;
    step;
    set_lu;
    for (int i = 0; i < 17; i++) step;
    chk("wrap_stall_cnt", 32'(stall_cnt), 4);
    rst = 1; step; rst = 0; idle;
    set_lu;
    for (int i = 0; i < 17; i++) step;
    chk("wrap17_stall_cnt", 32'(stall_cnt), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
